// File: rtl/seg7_scan_driver.sv
// Scan-indexed 4-digit seven-segment driver with per-frame snapshot and blanking gap.
// Optional leading-zero suppression when LZ_SUPPRESS_EN is defined.
module seg7_scan_driver #(
  parameter int BLANK_CYCLES = 64,
  parameter int CNT_W        = 8
) (
  input  logic        clk_27Mhz,
  input  logic        reset,
  input  logic [1:0]  digit_sel,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blink_mask,
  input  logic        blink_on,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, idx_q, idx_d;
  logic [15:0]      sdig_q, sdig_d;
  logic [3:0]       sdp_q, sdp_d;
  logic [3:0]       sbl_q, sbl_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             fs_q, fs_d;

  logic       change;
  logic [3:0] nib;
  logic       dark;
  logic [3:0] lz;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

`ifdef LZ_SUPPRESS_EN
  // Dark while this and every higher nibble is zero and no dp requested.
  always_comb begin
    lz[3] = (sdig_q[15:12] == 4'h0) && !sdp_q[3];
    lz[2] = (sdig_q[15:8] == 8'h00) && !sdp_q[2];
    lz[1] = (sdig_q[15:4] == 12'h000) && !sdp_q[1];
    lz[0] = 1'b0;
  end
`else
  assign lz = 4'b0000;
`endif

  assign change = (digit_sel != sel_q);
  assign nib    = sdig_q[{idx_q, 2'b00} +: 4];
  assign dark   = (blink_on && sbl_q[idx_q]) || lz[idx_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sdig_d  = sdig_q;
    sdp_d   = sdp_q;
    sbl_d   = sbl_q;
    an_d    = 4'b1111;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    fs_d    = 1'b0;
    if (change) begin
      state_d = BLANK;
      cnt_d   = CNT_W'(BLANK_CYCLES);
      idx_d   = digit_sel;
      if (digit_sel == 2'd3) begin
        sdig_d = digits;
        sdp_d  = dp_in;
        sbl_d  = blink_mask;
        fs_d   = 1'b1;
      end
    end else begin
      if (state_q == BLANK && cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        state_d = SHOW;
        if (!dark) begin
          an_d  = ~(4'b0001 << idx_q);
          seg_d = glyph(nib);
          dp_d  = ~sdp_q[idx_q];
        end
      end
    end
  end

  always_ff @(posedge clk_27Mhz) begin
    if (reset) begin
      state_q <= BLANK;
      cnt_q   <= CNT_W'(BLANK_CYCLES);
      sel_q   <= 2'd0;
      idx_q   <= 2'd0;
      sdig_q  <= 16'h0000;
      sdp_q   <= 4'h0;
      sbl_q   <= 4'h0;
      an_q    <= 4'b1111;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= digit_sel;
      idx_q   <= idx_d;
      sdig_q  <= sdig_d;
      sdp_q   <= sdp_d;
      sbl_q   <= sbl_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fs_q    <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Downstream consumer of the 2-bit scan index produced by the fast display-scan divider, which steps 3,2,1,0. It snapshots a 4-digit hex/BCD value once per scan frame and decodes the selected nibble to seven-segment glyphs. It drives active-low anodes, segments and decimal point. A programmable blanking gap at every digit change suppresses ghosting, and per-digit blink masking is supported.

Parameters:
BLANK_CYCLES, 64, clk_27Mhz cycles all anodes are held off after each scan-index change; legal range 0..255.
CNT_W, 8, width of the blanking counter; must satisfy 2^CNT_W > BLANK_CYCLES.

Ports:
clk_27Mhz  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
digit_sel  input  2  scan index from the scan divider; 3 = most-significant digit, first in each frame.
digits  input  16  four nibbles; digits[15:12] = digit 3 ... digits[3:0] = digit 0.
dp_in  input  4  decimal-point request per digit, active-high.
blink_mask  input  4  per-digit blink enable, active-high.
blink_on  input  1  blink phase level; 1 = blinking digits dark.
an  output  4  anodes, active-low; an[k] = digit k.
seg  output  7  segments, active-low, {g,f,e,d,c,b,a}.
dp  output  1  decimal point, active-low.
frame_start  output  1  one-cycle pulse when a new frame snapshot is taken.

Behaviour:
- All outputs are registered.
- Reset (synchronous, dominates everything):
  - an=4'b1111, seg=7'h7F, dp=1, frame_start=0.
  - sel_q=0, idx=0, snapshot registers=0, state=BLANK, cnt=BLANK_CYCLES.
- sel_q registers digit_sel every cycle.
- A change is detected when digit_sel != sel_q (combinational compare).
- FSM states: BLANK, SHOW.
- On any edge with a change detected, from either state:
  - state<=BLANK, cnt<=BLANK_CYCLES, idx<=digit_sel.
  - an<=1111, seg<=7F, dp<=1.
  - A change during BLANK restarts the gap with the new idx.
- Frame snapshot: if the change is to digit_sel==3, the same edge loads digits, dp_in and blink_mask into the snapshot registers and pulses frame_start=1 for one cycle. Input changes mid-frame never appear until the next frame, so there is no tearing.
- BLANK, no change: if cnt==0, go to SHOW and drive outputs for idx on that edge; else cnt<=cnt-1, outputs stay dark.
- Timing: the anode asserts exactly BLANK_CYCLES+1 edges after the change edge. With BLANK_CYCLES=0 it asserts on the next edge.
- SHOW, no change: outputs are refreshed every cycle from snapshot[idx].
  - an = one-hot-low at idx.
  - seg = glyph(nibble).
  - dp = ~snap_dp[idx].
- Blink: if blink_on and snap_blink[idx], then an=1111, seg=7F, dp=1 in SHOW; the FSM still advances normally.
- Glyph table, nibble 0..F, seg hex: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
- At most one anode is low in any cycle. An X/Z-free digit_sel is assumed from the upstream divider.

Optional Feature:
- Macro LZ_SUPPRESS_EN.
- Defined: leading-zero suppression. Digit k (k=3,2,1) is dark (an high, seg=7F, dp=1) when snapshot nibbles k..3 are all zero and snap_dp[k]=0. Digit 0 is never suppressed.
- Suppression is computed from the frame snapshot, so it is stable for the whole frame.
- Undefined: all four digits display, leading zeros included. No extra logic is compiled.

Test Plan:
- Reset check: assert reset 3 cycles with digit_sel=2 -> an=1111, seg=7F, dp=1, frame_start=0 during reset. After release, the change 0->2 restarts the gap, and an=1011 appears BLANK_CYCLES+1 edges after the change edge.
- Frame display: BLANK_CYCLES=4, digits=16'h12AF, dp_in=0100, step digit_sel 3,2,1,0 every 50 cycles:
  - Digit 3 shows an=0111, seg=79.
  - Digit 2 shows an=1011, seg=24, dp=0.
  - Digit 1 shows seg=08.
  - Digit 0 shows seg=0E.
  - Each digit is preceded by exactly 5 dark cycles, and a single frame_start pulse occurs at the 3 transition.
- No tearing: change digits to 16'h9999 while digit_sel=1 -> digits 1 and 0 still show A and F. 9s appear only after the next change to 3.
- Blink: blink_mask=0001, toggle blink_on -> digit 0 is dark while blink_on=1, digits 3..1 are unaffected, and scan timing is unchanged.
- Restart and reset mid-gap:
  - digit_sel changes 2->1 at cnt=2 in BLANK -> gap restarts, full BLANK_CYCLES+1 to the anode.
  - reset asserted in SHOW -> outputs dark on the next edge.
- LZ (with LZ_SUPPRESS_EN): digits=16'h0070 -> digits 3 and 2 dark, digit 1 shows 78, digit 0 shows 40. Without the macro, digits 3 and 2 show 40.
